// File: rtl/exibe_sequencia.sv
// Plays the stored game sequence on the LEDs, one ROM item per slot, each lit then blanked.
// Talks to the control unit through an iniciar/pronto handshake and owns its own ROM address port.
module exibe_sequencia #(
   parameter int TEMPO_ACESO   = 4,
   parameter int TEMPO_APAGADO = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] limite,
   input  logic [3:0] mem_dado,
   output logic [3:0] mem_endereco,
   output logic [3:0] leds,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL = 4'd0,
      BUSCA   = 4'd1,
      CARREGA = 4'd2,
      ACENDE  = 4'd3,
      APAGA   = 4'd4,
      PROXIMO = 4'd5,
      FIM     = 4'd6
   } estado_t;

   estado_t    estado_q;
   logic [3:0] endereco_q;
   logic [3:0] leds_q;
   logic [7:0] timer_q;
   logic [3:0] limiteReg_q;
   logic       pronto_q;
   logic       ocupado_q;

   // Sequencer: fetch (BUSCA/CARREGA), show, blank, then compare-before-increment so the address never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q    <= INICIAL;
         endereco_q  <= 4'd0;
         leds_q      <= 4'd0;
         timer_q     <= 8'd0;
         limiteReg_q <= 4'd0;
         pronto_q    <= 1'b0;
         ocupado_q   <= 1'b0;
      end else begin
         pronto_q <= 1'b0;
         case (estado_q)
            INICIAL: begin
               leds_q <= 4'd0;
               if (iniciar) begin
                  endereco_q  <= 4'd0;
                  limiteReg_q <= limite;
                  ocupado_q   <= 1'b1;
                  estado_q    <= BUSCA;
               end else begin
                  ocupado_q <= 1'b0;
               end
            end
            BUSCA: estado_q <= CARREGA;
            CARREGA: begin
               leds_q   <= mem_dado;
               timer_q  <= 8'd0;
               estado_q <= ACENDE;
            end
            ACENDE: begin
               if (timer_q == 8'(TEMPO_ACESO - 1)) begin
                  leds_q   <= 4'd0;
                  timer_q  <= 8'd0;
                  estado_q <= APAGA;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            APAGA: begin
               if (timer_q == 8'(TEMPO_APAGADO - 1)) begin
                  estado_q <= PROXIMO;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            PROXIMO: begin
               if (endereco_q == limiteReg_q) begin
                  pronto_q <= 1'b1;
                  estado_q <= FIM;
               end else begin
                  endereco_q <= endereco_q + 4'd1;
                  estado_q   <= BUSCA;
               end
            end
            FIM: begin
               ocupado_q <= 1'b0;
               estado_q  <= INICIAL;
            end
            default: begin
               leds_q    <= 4'd0;
               ocupado_q <= 1'b0;
               estado_q  <= INICIAL;
            end
         endcase
      end
   end

   assign mem_endereco = endereco_q;
   assign leds         = leds_q;
   assign ocupado      = ocupado_q;
   assign pronto       = pronto_q;
   assign db_estado    = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia: a behavioural ROM plus a cycle-position reference model
// derived from the per-item timing (show, blank, fetch overhead) rather than from the FSM itself.
module tb_exibe_sequencia;

   localparam int ACESO   = 4;
   localparam int APAGADO = 2;
   localparam int PERIODO = ACESO + APAGADO + 3;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [3:0] limite;
   logic [3:0] memDado;
   logic [3:0] memEndereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [3:0] dbEstado;

   logic [3:0] rom [16];
   int vectors;
   int miscompares;

   exibe_sequencia #(
      .TEMPO_ACESO  (ACESO),
      .TEMPO_APAGADO(APAGADO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .iniciar     (iniciar),
      .limite      (limite),
      .mem_dado    (memDado),
      .mem_endereco(memEndereco),
      .leds        (leds),
      .ocupado     (ocupado),
      .pronto      (pronto),
      .db_estado   (dbEstado)
   );

   // Synchronous ROM: data follows the address one cycle later.
   always @(posedge clock) memDado <= rom[memEndereco];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   task automatic checkIdle(input string tag, input logic [3:0] endEsperado);
      checkOutput({tag, ".estado"},   8'(dbEstado),    8'd0);
      checkOutput({tag, ".leds"},     8'(leds),        8'd0);
      checkOutput({tag, ".pronto"},   8'(pronto),      8'd0);
      checkOutput({tag, ".ocupado"},  8'(ocupado),     8'd0);
      checkOutput({tag, ".endereco"}, 8'(memEndereco), 8'(endEsperado));
   endtask

   // Runs one sequence; resetAt>0 aborts it with reset (and a competing iniciar) during that cycle.
   task automatic applyStimulus(input int lim, input bit interfere, input int resetAt);
      int total;
      int k;
      int ph;
      logic [3:0] expLeds;
      logic [3:0] expEstado;
      logic [3:0] expEnd;
      logic       expPronto;
      total = (lim + 1) * PERIODO + 1;
      @(negedge clock);
      limite  = 4'(lim);
      iniciar = 1'b1;
      @(negedge clock);
      for (int c = 1; c <= total; c++) begin
         k  = (c - 1) / PERIODO;
         ph = (c - 1) % PERIODO;
         if (c == total) begin
            expLeds = 4'd0; expEstado = 4'd6; expEnd = 4'(lim); expPronto = 1'b1;
         end else begin
            expLeds   = (ph >= 2 && ph < 2 + ACESO) ? rom[k] : 4'd0;
            expEnd    = 4'(k);
            expPronto = 1'b0;
            if (ph == 0)                   expEstado = 4'd1;
            else if (ph == 1)              expEstado = 4'd2;
            else if (ph < 2 + ACESO)       expEstado = 4'd3;
            else if (ph < PERIODO - 1)     expEstado = 4'd4;
            else                           expEstado = 4'd5;
         end
         checkOutput("seq.leds",     8'(leds),        8'(expLeds));
         checkOutput("seq.estado",   8'(dbEstado),    8'(expEstado));
         checkOutput("seq.endereco", 8'(memEndereco), 8'(expEnd));
         checkOutput("seq.pronto",   8'(pronto),      8'(expPronto));
         checkOutput("seq.ocupado",  8'(ocupado),     8'd1);
         if (c == resetAt) begin
            reset   = 1'b1;
            iniciar = 1'b1;
            @(negedge clock);
            checkIdle("abort", 4'd0);
            reset   = 1'b0;
            iniciar = 1'b0;
            @(negedge clock);
            checkIdle("abortHold", 4'd0);
            return;
         end
         if (interfere && c < total - 1) begin
            iniciar = 1'($urandom);
            limite  = 4'($urandom);
         end else begin
            iniciar = 1'b0;
         end
         @(negedge clock);
      end
      checkIdle("fim", 4'(lim));
   endtask

   initial begin
      int lim;
      int resetAt;
      vectors     = 0;
      miscompares = 0;
      rom = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
              4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
      reset   = 1'b1;
      iniciar = 1'b0;
      limite  = 4'd0;
      repeat (3) @(negedge clock);
      checkIdle("reset", 4'd0);
      reset = 1'b0;

      applyStimulus(0, 1'b0, 0);
      applyStimulus(3, 1'b0, 0);
      applyStimulus(15, 1'b1, 0);
      applyStimulus(2, 1'b1, 0);
      applyStimulus(3, 1'b0, 5);
      applyStimulus(3, 1'b0, 0);
      for (int r = 0; r < 8; r++) begin
         lim     = int'($urandom_range(0, 15));
         resetAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (lim + 1) * PERIODO)) : 0;
         applyStimulus(lim, 1'($urandom), resetAt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
